door_sequencer: RTL

DOOR_SEQUENCER -- requirements
Module: door_sequencer

---
 rtl/door_pkg.sv | 27 ++
 rtl/door_req_arb.sv | 44 ++++
 rtl/door_sequencer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/door_pkg.sv
// Shared types and defaults for the door sequencer: FSM state encoding,
// travel-direction flag, Grant encodings and default timing parameters.
package door_pkg;

  typedef enum logic [2:0] {
    ST_STOPPED = 3'd0,
    ST_OPENING = 3'd1,
    ST_OPEN    = 3'd2,
    ST_CLOSING = 3'd3,
    ST_CLOSED  = 3'd4,
    ST_FAULT   = 3'd5
  } door_state_t;

  typedef enum logic {
    DIR_CLOSING = 1'b0,
    DIR_OPENING = 1'b1
  } door_dir_t;

  localparam logic [1:0] GRANT_NONE   = 2'b00;
  localparam logic [1:0] GRANT_WALL   = 2'b01;
  localparam logic [1:0] GRANT_REMOTE = 2'b10;

  localparam int TRAVEL_MAX_DEF = 1000;
  localparam int AUTO_CLOSE_DEF = 500;
  localparam int CNT_W_DEF      = 16;

endpackage

// File: rtl/door_req_arb.sv
// Rising-edge detection of the two door buttons and fixed-priority
// arbitration (wall beats remote; a losing edge is dropped).
module door_req_arb
  import door_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_wall,
  input  logic       btn_remote,
  output logic       req,
  output logic [1:0] req_grant
);

  logic wall_q;
  logic remote_q;
  logic wall_edge;
  logic remote_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wall_q   <= 1'b0;
      remote_q <= 1'b0;
    end else begin
      wall_q   <= btn_wall;
      remote_q <= btn_remote;
    end
  end

  assign wall_edge   = btn_wall & ~wall_q;
  assign remote_edge = btn_remote & ~remote_q;

  always_comb begin
    req       = 1'b0;
    req_grant = GRANT_NONE;
    if (wall_edge) begin
      req       = 1'b1;
      req_grant = GRANT_WALL;
    end else if (remote_edge) begin
      req       = 1'b1;
      req_grant = GRANT_REMOTE;
    end
  end

endmodule

// File: rtl/door_sequencer.sv
// Garage-door sequencer FSM with travel timeout and fault handling.
// Optional auto-close from OPEN is enabled by defining DOOR_AUTO_CLOSE_EN.
module door_sequencer
  import door_pkg::*;
#(
  parameter int TRAVEL_MAX = TRAVEL_MAX_DEF,
  parameter int AUTO_CLOSE = AUTO_CLOSE_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Btn_Wall,
  input  logic       Btn_Remote,
  input  logic       Up_Max,
  input  logic       Down_Max,
  input  logic       Obstruct,
  input  logic       Clr_Fault,
  output logic       Up_Motor,
  output logic       Down_Motor,
  output logic [1:0] Grant,
  output logic       Fault
);

  if (TRAVEL_MAX < 1 || longint'(TRAVEL_MAX) > (longint'(1) << CNT_W) ||
      AUTO_CLOSE < 1 || longint'(AUTO_CLOSE) > (longint'(1) << CNT_W)) begin : g_param_check
    $error("door_sequencer: TRAVEL_MAX/AUTO_CLOSE do not fit the CNT_W counter");
  end

  localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_MAX - 1);
`ifdef DOOR_AUTO_CLOSE_EN
  localparam logic [CNT_W-1:0] AUTO_LAST = CNT_W'(AUTO_CLOSE - 1);
`endif

  door_state_t      state, state_next;
  door_dir_t        dir;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [1:0]       grant_reg;
  logic             req;
  logic [1:0]       req_grant;
  logic             accept;
  logic             cnt_clear;
  logic             conflict;

  door_req_arb u_arb (
    .clk        (CLK),
    .rst_n      (RST),
    .btn_wall   (Btn_Wall),
    .btn_remote (Btn_Remote),
    .req        (req),
    .req_grant  (req_grant)
  );

  assign conflict = Up_Max & Down_Max;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= ST_STOPPED;
      dir       <= DIR_CLOSING;
      cnt       <= '0;
      grant_reg <= GRANT_NONE;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      grant_reg <= accept ? req_grant : GRANT_NONE;
      if (state_next == ST_OPENING) begin
        dir <= DIR_OPENING;
      end else if (state_next == ST_CLOSING) begin
        dir <= DIR_CLOSING;
      end
    end
  end

  // accept is raised only on the branch where the request itself causes the move
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    cnt_clear  = 1'b0;
    case (state)
      ST_STOPPED: begin
        if (req) begin
          accept     = 1'b1;
          state_next = (dir == DIR_CLOSING) ? ST_OPENING : ST_CLOSING;
        end
      end
      ST_CLOSED: begin
        if (req) begin
          accept     = 1'b1;
          state_next = ST_OPENING;
        end
      end
      ST_OPENING: begin
        if (conflict) begin
          state_next = ST_FAULT;
        end else if (Up_Max) begin
          state_next = ST_OPEN;
        end else if (req) begin
          accept     = 1'b1;
          state_next = ST_STOPPED;
        end else if (cnt == TRAVEL_LAST) begin
          state_next = ST_FAULT;
        end
      end
      ST_OPEN: begin
        if (req) begin
          accept     = 1'b1;
          state_next = ST_CLOSING;
        end
`ifdef DOOR_AUTO_CLOSE_EN
        else if (cnt == AUTO_LAST) begin
          if (Obstruct) begin
            cnt_clear = 1'b1;
          end else begin
            state_next = ST_CLOSING;
          end
        end
`else
        else begin
          cnt_clear = 1'b1;
        end
`endif
      end
      ST_CLOSING: begin
        if (conflict) begin
          state_next = ST_FAULT;
        end else if (Obstruct) begin
          state_next = ST_OPENING;
        end else if (Down_Max) begin
          state_next = ST_CLOSED;
        end else if (req) begin
          accept     = 1'b1;
          state_next = ST_STOPPED;
        end else if (cnt == TRAVEL_LAST) begin
          state_next = ST_FAULT;
        end
      end
      ST_FAULT: begin
        if (Clr_Fault) begin
          state_next = ST_STOPPED;
        end
      end
      default: state_next = ST_STOPPED;
    endcase
  end

  // Counter restarts on any state change and saturates instead of wrapping
  always_comb begin
    cnt_next = cnt;
    if (state_next != state || cnt_clear) begin
      cnt_next = '0;
    end else if (cnt != {CNT_W{1'b1}}) begin
      cnt_next = cnt + 1'b1;
    end
  end

  assign Up_Motor   = (state == ST_OPENING);
  assign Down_Motor = (state == ST_CLOSING);
  assign Fault      = (state == ST_FAULT);
  assign Grant      = grant_reg;

endmodule
